// File: rtl/fifo_pkg.sv
// Shared sizing helpers and pointer arithmetic for the multi-entry FIFO.
package fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Occupancy runs 0..depth inclusive, so it needs one more code than a pointer.
    function automatic int countWidth(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    // Wrap explicitly at depth-1 so non-power-of-two depths work.
    function automatic int advancePtr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrapping storage pointer with synchronous reset/flush and an advance enable.
module fifo_ptr_ctr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = ptrWidth(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          adv,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptrReg;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            ptrReg <= '0;
        end else if (adv) begin
            ptrReg <= PW'(advancePtr(int'(ptrReg), DEPTH));
        end
    end

    assign ptr = ptrReg;

endmodule

// File: rtl/fifo_n.sv
// Parametrised synchronous FIFO with occupancy count, almost flags and flush.
module fifo_n
    import fifo_pkg::*;
#(
    parameter int  WIDTH    = 1,
    parameter int  DEPTH    = 4,
    parameter int  AF_LEVEL = DEPTH - 1,
    parameter int  AE_LEVEL = 1,
    localparam int CW       = countWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    output logic             enq_rdy,
    input  logic             enq_en,
    input  logic [WIDTH-1:0] enq_val,
    output logic             deq_rdy,
    input  logic             deq_en,
    output logic [WIDTH-1:0] deq_val,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int PW = ptrWidth(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    headPtr;
    logic [PW-1:0]    tailPtr;
    logic [CW-1:0]    countReg;
    logic [CW-1:0]    countNext;
    logic             full;
    logic             empty;
    logic             doEnq;
    logic             doDeq;

    assign full  = (countReg == CW'(DEPTH));
    assign empty = (countReg == '0);

    // Ready gating makes full/empty concurrency fall out naturally: no bypass, no pass-through.
    assign doEnq = enq_en && !full;
    assign doDeq = deq_en && !empty;

    fifo_ptr_ctr #(.DEPTH(DEPTH), .PW(PW)) u_headCtr (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .adv  (doDeq),
        .ptr  (headPtr)
    );

    fifo_ptr_ctr #(.DEPTH(DEPTH), .PW(PW)) u_tailCtr (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .adv  (doEnq),
        .ptr  (tailPtr)
    );

    // Storage is deliberately not reset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (doEnq && rst_n && !clear) begin
            mem[tailPtr] <= enq_val;
        end
    end

    always_comb begin
        countNext = countReg;
        if (doEnq && !doDeq) begin
            countNext = countReg + CW'(1);
        end else if (doDeq && !doEnq) begin
            countNext = countReg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            countReg <= '0;
        end else begin
            countReg <= countNext;
        end
    end

    assign enq_rdy      = !full;
    assign deq_rdy      = !empty;
    assign deq_val      = empty ? '0 : mem[headPtr];
    assign count        = countReg;
    assign almost_full  = (int'(countReg) >= AF_LEVEL);
    assign almost_empty = (int'(countReg) <= AE_LEVEL);

endmodule

// File: tb/tb_fifo_n.sv
// Self-checking bench for fifo_n: directed tables, corner sequences and randomised scoreboard runs.
module tb_fifo_n;

    logic clk;
    logic rst_n;
    int   nVec;
    int   nMis;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instance A: WIDTH=8, DEPTH=4
    logic       aClr, aEnq, aDeq, aEnqRdy, aDeqRdy, aAf, aAe;
    logic [7:0] aVal, aDv;
    logic [2:0] aCnt;
    // Instance B: WIDTH=8, DEPTH=3
    logic       bClr, bEnq, bDeq, bEnqRdy, bDeqRdy, bAf, bAe;
    logic [7:0] bVal, bDv;
    logic [1:0] bCnt;
    // Instance C: WIDTH=1, DEPTH=2
    logic       cClr, cEnq, cDeq, cEnqRdy, cDeqRdy, cAf, cAe;
    logic       cVal, cDv;
    logic [1:0] cCnt;
    // Instance D: WIDTH=32, DEPTH=5
    logic        dClr, dEnq, dDeq, dEnqRdy, dDeqRdy, dAf, dAe;
    logic [31:0] dVal, dDv;
    logic [2:0]  dCnt;

    fifo_n #(.WIDTH(8), .DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(aClr), .enq_rdy(aEnqRdy), .enq_en(aEnq),
        .enq_val(aVal), .deq_rdy(aDeqRdy), .deq_en(aDeq), .deq_val(aDv), .count(aCnt),
        .almost_full(aAf), .almost_empty(aAe));

    fifo_n #(.WIDTH(8), .DEPTH(3)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(bClr), .enq_rdy(bEnqRdy), .enq_en(bEnq),
        .enq_val(bVal), .deq_rdy(bDeqRdy), .deq_en(bDeq), .deq_val(bDv), .count(bCnt),
        .almost_full(bAf), .almost_empty(bAe));

    fifo_n #(.WIDTH(1), .DEPTH(2)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(cClr), .enq_rdy(cEnqRdy), .enq_en(cEnq),
        .enq_val(cVal), .deq_rdy(cDeqRdy), .deq_en(cDeq), .deq_val(cDv), .count(cCnt),
        .almost_full(cAf), .almost_empty(cAe));

    fifo_n #(.WIDTH(32), .DEPTH(5)) u_d (
        .clk(clk), .rst_n(rst_n), .clear(dClr), .enq_rdy(dEnqRdy), .enq_en(dEnq),
        .enq_val(dVal), .deq_rdy(dDeqRdy), .deq_en(dDeq), .deq_val(dDv), .count(dCnt),
        .almost_full(dAf), .almost_empty(dAe));

    typedef struct {
        logic       enq;
        logic       deq;
        logic [7:0] val;
        int         cnt;
        logic       enqRdy;
        logic       deqRdy;
        logic [7:0] head;
        logic       af;
        logic       ae;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkA(input string tag, input int cnt, input logic er, input logic dr,
                          input logic [7:0] dv, input logic af, input logic ae);
        chk({tag, ".count"}, 32'(aCnt), 32'(cnt));
        chk({tag, ".enq_rdy"}, 32'(aEnqRdy), 32'(er));
        chk({tag, ".deq_rdy"}, 32'(aDeqRdy), 32'(dr));
        chk({tag, ".deq_val"}, 32'(aDv), 32'(dv));
        chk({tag, ".almost_full"}, 32'(aAf), 32'(af));
        chk({tag, ".almost_empty"}, 32'(aAe), 32'(ae));
        $display("%s: count=%0d enq_rdy=%0b deq_rdy=%0b deq_val=%02h af=%0b ae=%0b",
                 tag, aCnt, aEnqRdy, aDeqRdy, aDv, aAf, aAe);
    endtask

    task automatic checkB(input string tag, input int cnt, input logic er, input logic dr,
                          input logic [7:0] dv);
        chk({tag, ".count"}, 32'(bCnt), 32'(cnt));
        chk({tag, ".enq_rdy"}, 32'(bEnqRdy), 32'(er));
        chk({tag, ".deq_rdy"}, 32'(bDeqRdy), 32'(dr));
        chk({tag, ".deq_val"}, 32'(bDv), 32'(dv));
        $display("%s: count=%0d enq_rdy=%0b deq_rdy=%0b deq_val=%02h",
                 tag, bCnt, bEnqRdy, bDeqRdy, bDv);
    endtask

    // Compares a DUT's outputs with what the occupancy/head of a reference queue implies.
    task automatic checkModel(input string tag, input int depth, input int afl, input int ael,
                              input int sz, input logic [31:0] head, input int actCnt,
                              input logic er, input logic dr, input logic [31:0] dv,
                              input logic af, input logic ae);
        chk({tag, ".count"}, 32'(actCnt), 32'(sz));
        chk({tag, ".enq_rdy"}, 32'(er), 32'(sz < depth));
        chk({tag, ".deq_rdy"}, 32'(dr), 32'(sz > 0));
        chk({tag, ".deq_val"}, dv, (sz > 0) ? head : 32'h0);
        chk({tag, ".almost_full"}, 32'(af), 32'(sz >= afl));
        chk({tag, ".almost_empty"}, 32'(ae), 32'(sz <= ael));
    endtask

    logic [31:0] qc[$];
    logic [31:0] qd[$];

    initial begin
        nVec = 0;
        nMis = 0;
        rst_n = 1'b0;
        {aClr, aEnq, aDeq, aVal} = '0;
        {bClr, bEnq, bDeq, bVal} = '0;
        {cClr, cEnq, cDeq, cVal} = '0;
        {dClr, dEnq, dDeq, dVal} = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        checkA("reset_idle", 0, 1, 0, 8'h00, 0, 1);

        // Fill to full, attempt overflow, drain, attempt underflow.
        tbl[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h33, 3, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 8'h44, 4, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h55, 4, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h00, 3, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 2, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            aEnq = tbl[i].enq;
            aDeq = tbl[i].deq;
            aVal = tbl[i].val;
            step();
            checkA($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].enqRdy, tbl[i].deqRdy,
                   tbl[i].head, tbl[i].af, tbl[i].ae);
        end
        aEnq = 0;
        aDeq = 0;

        // Flush with three entries queued and a simultaneous enqueue.
        for (int i = 1; i <= 3; i++) begin
            aEnq = 1;
            aVal = 8'(i);
            step();
        end
        aClr = 1;
        aEnq = 1;
        aVal = 8'h77;
        step();
        aClr = 0;
        aEnq = 0;
        checkA("clear", 0, 1, 0, 8'h00, 0, 1);
        step();
        checkA("clear_idle", 0, 1, 0, 8'h00, 0, 1);
        aEnq = 1;
        aVal = 8'h88;
        step();
        aEnq = 0;
        checkA("clear_refill", 1, 1, 1, 8'h88, 0, 1);

        // Wrap and concurrency on a non-power-of-two depth.
        for (int k = 0; k < 2; k++) begin
            bEnq = 1;
            bVal = 8'h10 + 8'(k);
            step();
            checkB($sformatf("b_fill%0d", k), k + 1, 1, 1, 8'h10);
        end
        for (int i = 0; i < 10; i++) begin
            bEnq = 1;
            bDeq = 1;
            bVal = 8'h10 + 8'(i + 2);
            step();
            checkB($sformatf("b_wrap%0d", i), 2, 1, 1, 8'h10 + 8'(i + 1));
        end
        bEnq = 0;
        step();
        checkB("b_drain0", 1, 1, 1, 8'h1b);
        step();
        checkB("b_drain1", 0, 1, 0, 8'h00);
        bEnq = 1;
        bVal = 8'hAA;
        step();
        checkB("b_empty_both", 1, 1, 1, 8'hAA);
        bDeq = 0;
        bVal = 8'hB1;
        step();
        checkB("b_fillB1", 2, 1, 1, 8'hAA);
        bVal = 8'hB2;
        step();
        checkB("b_fillB2", 3, 0, 1, 8'hAA);
        bDeq = 1;
        bVal = 8'hCC;
        step();
        checkB("b_full_both", 2, 1, 1, 8'hB1);
        bEnq = 0;
        step();
        checkB("b_tail0", 1, 1, 1, 8'hB2);
        step();
        checkB("b_tail1", 0, 1, 0, 8'h00);
        bDeq = 0;

        // Reset mid-stream: A currently holds one entry; add two, then reset while enqueuing.
        for (int i = 1; i <= 2; i++) begin
            aEnq = 1;
            aVal = 8'h60 + 8'(i);
            step();
        end
        aVal = 8'h66;
        rst_n = 0;
        step();
        rst_n = 1;
        aEnq = 0;
        checkA("rst_mid", 0, 1, 0, 8'h00, 0, 1);
        step();
        checkA("rst_idle", 0, 1, 0, 8'h00, 0, 1);
        aEnq = 1;
        aVal = 8'h99;
        step();
        aEnq = 0;
        checkA("rst_refill", 1, 1, 1, 8'h99, 0, 1);

        // Randomised push/pop against reference queues, biased in phases toward full and empty.
        for (int i = 0; i < 10000; i++) begin
            int pe;
            pe = ((i / 500) % 2 == 1) ? 70 : 30;
            cEnq = ($urandom_range(0, 99) < pe);
            cDeq = ($urandom_range(0, 99) < 50);
            cVal = 1'($urandom);
            cClr = ($urandom_range(0, 199) == 0);
            dEnq = ($urandom_range(0, 99) < pe);
            dDeq = ($urandom_range(0, 99) < 50);
            dVal = $urandom;
            dClr = ($urandom_range(0, 199) == 0);

            if (cClr) begin
                qc.delete();
            end else begin
                bit takeE, takeD;
                takeE = cEnq && (qc.size() < 2);
                takeD = cDeq && (qc.size() > 0);
                if (takeD) void'(qc.pop_front());
                if (takeE) qc.push_back(32'(cVal));
            end
            if (dClr) begin
                qd.delete();
            end else begin
                bit takeE, takeD;
                takeE = dEnq && (qd.size() < 5);
                takeD = dDeq && (qd.size() > 0);
                if (takeD) void'(qd.pop_front());
                if (takeE) qd.push_back(dVal);
            end

            step();
            checkModel("rnd_c", 2, 1, 1, qc.size(), (qc.size() > 0) ? qc[0] : 32'h0,
                       int'(cCnt), cEnqRdy, cDeqRdy, 32'(cDv), cAf, cAe);
            checkModel("rnd_d", 5, 4, 1, qd.size(), (qd.size() > 0) ? qd[0] : 32'h0,
                       int'(dCnt), dEnqRdy, dDeqRdy, dDv, dAf, dAe);
            if (i % 1000 == 999) begin
                $display("rnd cycle %0d: c.count=%0d d.count=%0d d.deq_val=%08h",
                         i + 1, cCnt, dCnt, dDv);
            end
        end
        {cClr, cEnq, cDeq, dClr, dEnq, dDeq} = '0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
